two_sum_feeder: RTL and testbench

Upstream stage of the streaming two-sum solver. It buffers one array plus its target from a host load port, then replays the array to the solver as a number/number_valid/number_last stream with target held stable. It captures the solver's index pair and reports a per-array result (found/not found) to the host. One array is in flight at a time.

---
 rtl/two_sum_pkg.sv | 18 +
 rtl/two_sum_feeder_buffer.sv | 28 ++
 rtl/two_sum_feeder.sv | 143 ++++++++++++++
 tb/tb_two_sum_feeder.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/two_sum_pkg.sv
// Shared definitions for the streaming two-sum feeder and solver:
// default element width, index width derivation and the feeder state encoding.
package two_sum_pkg;

    localparam int DEFAULT_DATA_WIDTH = 2;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_STREAM = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    // Index width for a buffer of the given depth (never narrower than one bit)
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/two_sum_feeder_buffer.sv
// Array buffer for the two-sum feeder: synchronous write port, combinational read port.
module feeder_buffer
    import two_sum_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ARRAY_SIZE = 2**DATA_WIDTH,
    parameter int ADDR_W     = idx_width(ARRAY_SIZE)
) (
    input  logic                         clk,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic signed [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic signed [DATA_WIDTH-1:0] rd_data
);

    logic signed [DATA_WIDTH-1:0] mem [ARRAY_SIZE];

    // Store each accepted host element at its write address
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/two_sum_feeder.sv
// Two-sum feeder: buffers one array plus target from the host, replays it to the
// solver as a number stream, captures the solver's index pair and reports one
// result pulse per array.
module two_sum_feeder
    import two_sum_pkg::*;
#(
    parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int  ARRAY_SIZE = 2**DATA_WIDTH,
    parameter bit  EARLY_EXIT = 1'b0,
    localparam int IDX_W      = idx_width(ARRAY_SIZE)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] load_data,
    input  logic                         load_valid,
    input  logic                         load_last,
    input  logic signed [DATA_WIDTH-1:0] load_target,
    output logic                         load_ready,
    output logic signed [DATA_WIDTH-1:0] number,
    output logic                         number_valid,
    output logic                         number_last,
    output logic signed [DATA_WIDTH-1:0] target,
    input  logic [IDX_W-1:0]             sol_index1,
    input  logic [IDX_W-1:0]             sol_index2,
    input  logic                         sol_valid,
    output logic [IDX_W-1:0]             res_index1,
    output logic [IDX_W-1:0]             res_index2,
    output logic                         res_found,
    output logic                         res_valid
);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] wr_ptr, rd_ptr, last_idx;
    logic [IDX_W-1:0] cap_index1, cap_index2;
    logic             captured;
    logic             accept, load_end, capture_now;

    // load_ready is only ever high in LOAD, so it alone qualifies a host beat
    assign accept      = load_valid && load_ready;
    assign load_end    = accept && (load_last || (wr_ptr == IDX_W'(ARRAY_SIZE - 1)));
    assign capture_now = (state_q != ST_LOAD) && sol_valid && !captured;

    feeder_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .ARRAY_SIZE (ARRAY_SIZE),
        .ADDR_W     (IDX_W)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (wr_ptr),
        .wr_data (load_data),
        .rd_addr (rd_ptr),
        .rd_data (number)
    );

    // Next state and stream handshake; with EARLY_EXIT a solver hit closes the stream on the current beat
    always_comb begin
        state_d      = state_q;
        number_valid = 1'b0;
        number_last  = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (load_end) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                number_valid = 1'b1;
                number_last  = (rd_ptr == last_idx) || (EARLY_EXIT && sol_valid);
                if (number_last) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                state_d = ST_LOAD;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Pointers, target latch, first-hit capture and the per-array result pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            load_ready <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            last_idx   <= '0;
            target     <= '0;
            captured   <= 1'b0;
            cap_index1 <= '0;
            cap_index2 <= '0;
            res_index1 <= '0;
            res_index2 <= '0;
            res_found  <= 1'b0;
            res_valid  <= 1'b0;
        end else begin
            load_ready <= (state_d == ST_LOAD);
            res_valid  <= (state_q == ST_WAIT);

            if (accept) begin
                wr_ptr <= wr_ptr + IDX_W'(1);
            end
            if (load_end) begin
                last_idx <= wr_ptr;
                target   <= load_target;
            end

            if (number_valid) begin
                if (number_last) begin
                    rd_ptr <= '0;
                    wr_ptr <= '0;
                end else begin
                    rd_ptr <= rd_ptr + IDX_W'(1);
                end
            end

            if (capture_now) begin
                captured   <= 1'b1;
                cap_index1 <= sol_index1;
                cap_index2 <= sol_index2;
            end

            if (state_q == ST_WAIT) begin
                captured   <= 1'b0;
                res_found  <= captured || capture_now;
                res_index1 <= capture_now ? sol_index1 : cap_index1;
                res_index2 <= capture_now ? sol_index2 : cap_index2;
            end
        end
    end

endmodule

// File: tb/tb_two_sum_feeder.sv
// Testbench for two_sum_feeder: two instances (EARLY_EXIT off/on) share the host
// bus, a behavioural solver answers each stream, and a scoreboard monitor checks
// every beat and every result pulse against hand-computed expectations.
module tb_two_sum_feeder;

    localparam int DW = 2;
    localparam int IW = 2;

    typedef struct {
        int num;
        bit last;
        int tgt;
    } beat_t;

    typedef struct {
        bit found;
        int i1;
        int i2;
    } res_t;

    logic clk;
    logic rst;
    logic sel;
    logic signed [DW-1:0] load_data;
    logic                 load_valid;
    logic                 load_last;
    logic signed [DW-1:0] load_target;
    logic [IW-1:0]        sol_index1, sol_index2;
    logic                 sol_valid;

    logic                 load_ready_a, load_ready_b;
    logic signed [DW-1:0] number_a, number_b, target_a, target_b;
    logic                 number_valid_a, number_valid_b, number_last_a, number_last_b;
    logic [IW-1:0]        res_index1_a, res_index1_b, res_index2_a, res_index2_b;
    logic                 res_found_a, res_found_b, res_valid_a, res_valid_b;

    logic                 load_ready;
    logic signed [DW-1:0] number, target;
    logic                 number_valid, number_last;
    logic [IW-1:0]        res_index1, res_index2;
    logic                 res_found, res_valid;

    beat_t beat_q[$];
    res_t  res_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cycle = 0;
    int    last_cycle = -100;

    int    m_seen[4];
    int    m_idx = 0;
    bit    m_found = 0;
    bit    m_drop = 0;
    bit    nxt_valid = 0;
    int    nxt_i1 = 0;
    int    nxt_i2 = 0;

    two_sum_feeder #(.DATA_WIDTH(DW), .ARRAY_SIZE(4), .EARLY_EXIT(1'b0)) dut_a (
        .clk          (clk),
        .rst          (rst),
        .load_data    (load_data),
        .load_valid   (load_valid && !sel),
        .load_last    (load_last),
        .load_target  (load_target),
        .load_ready   (load_ready_a),
        .number       (number_a),
        .number_valid (number_valid_a),
        .number_last  (number_last_a),
        .target       (target_a),
        .sol_index1   (sol_index1),
        .sol_index2   (sol_index2),
        .sol_valid    (sol_valid),
        .res_index1   (res_index1_a),
        .res_index2   (res_index2_a),
        .res_found    (res_found_a),
        .res_valid    (res_valid_a)
    );

    two_sum_feeder #(.DATA_WIDTH(DW), .ARRAY_SIZE(4), .EARLY_EXIT(1'b1)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .load_data    (load_data),
        .load_valid   (load_valid && sel),
        .load_last    (load_last),
        .load_target  (load_target),
        .load_ready   (load_ready_b),
        .number       (number_b),
        .number_valid (number_valid_b),
        .number_last  (number_last_b),
        .target       (target_b),
        .sol_index1   (sol_index1),
        .sol_index2   (sol_index2),
        .sol_valid    (sol_valid),
        .res_index1   (res_index1_b),
        .res_index2   (res_index2_b),
        .res_found    (res_found_b),
        .res_valid    (res_valid_b)
    );

    assign load_ready   = sel ? load_ready_b   : load_ready_a;
    assign number       = sel ? number_b       : number_a;
    assign number_valid = sel ? number_valid_b : number_valid_a;
    assign number_last  = sel ? number_last_b  : number_last_a;
    assign target       = sel ? target_b       : target_a;
    assign res_index1   = sel ? res_index1_b   : res_index1_a;
    assign res_index2   = sel ? res_index2_b   : res_index2_a;
    assign res_found    = sel ? res_found_b    : res_found_a;
    assign res_valid    = sel ? res_valid_b    : res_valid_a;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Loads one array; pushes the hand-computed beats and result into the scoreboard first
    task automatic applyStimulus(input int n, input int e0, input int e1, input int e2, input int e3,
                                 input int tgt, input bit use_last, input int exp_beats,
                                 input bit push_result, input bit exp_found, input int exp_i1,
                                 input int exp_i2, input bit extra_beat);
        int    elems[4];
        int    waited;
        beat_t b;
        res_t  r;
        elems[0] = e0;
        elems[1] = e1;
        elems[2] = e2;
        elems[3] = e3;
        for (int i = 0; i < exp_beats; i++) begin
            b.num  = elems[i];
            b.last = (i == exp_beats - 1);
            b.tgt  = tgt;
            beat_q.push_back(b);
        end
        if (push_result) begin
            r.found = exp_found;
            r.i1    = exp_i1;
            r.i2    = exp_i2;
            res_q.push_back(r);
        end
        waited = 0;
        while (!load_ready && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checkOutput("load_ready_before_load", int'(load_ready), 1);
        for (int i = 0; i < n; i++) begin
            load_valid  = 1'b1;
            load_data   = DW'(elems[i]);
            load_last   = use_last && (i == n - 1);
            load_target = DW'(tgt);
            @(posedge clk);
            #1;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        if (extra_beat) begin
            checkOutput("load_ready_after_overflow", int'(load_ready), 0);
            load_valid  = 1'b1;
            load_data   = DW'(1);
            load_last   = 1'b1;
            load_target = DW'(0);
            @(posedge clk);
            #1;
            load_valid = 1'b0;
            load_last  = 1'b0;
        end
    endtask

    // Waits (bounded) until every pushed beat and result has been consumed
    task automatic drain(input string name);
        int waited;
        waited = 0;
        while ((beat_q.size() != 0 || res_q.size() != 0) && waited < 60) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checkOutput(name, beat_q.size() + res_q.size(), 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Behavioural solver: flags the first pair summing to target one cycle after the
    // matching beat and holds index_valid until the cycle after number_last
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                m_idx     = 0;
                m_found   = 0;
                m_drop    = 0;
                nxt_valid = 0;
            end else begin
                if (m_drop) begin
                    m_idx     = 0;
                    m_found   = 0;
                    m_drop    = 0;
                    nxt_valid = 0;
                end
                if (number_valid) begin
                    for (int j = 0; j < m_idx; j++) begin
                        if (!m_found && (m_seen[j] + int'(number) == int'(target))) begin
                            m_found   = 1;
                            nxt_valid = 1;
                            nxt_i1    = m_idx;
                            nxt_i2    = j;
                        end
                    end
                    if (m_idx < 4) m_seen[m_idx] = int'(number);
                    m_idx++;
                    if (number_last) m_drop = 1;
                end
            end
        end
    end

    initial begin
        sol_valid  = 1'b0;
        sol_index1 = '0;
        sol_index2 = '0;
        forever begin
            @(posedge clk);
            #1;
            sol_valid  = nxt_valid;
            sol_index1 = IW'(nxt_i1);
            sol_index2 = IW'(nxt_i2);
        end
    end

    // Scoreboard monitor: compares every beat and every result pulse against the queues
    initial begin
        beat_t b;
        res_t  r;
        forever begin
            @(negedge clk);
            cycle++;
            if (rst) begin
                beat_q.delete();
                last_cycle = -100;
            end else begin
                if (number_valid) begin
                    if (beat_q.size() == 0) begin
                        checkOutput("unexpected_beat", 1, 0);
                    end else begin
                        b = beat_q.pop_front();
                        checkOutput("number", int'(number), b.num);
                        checkOutput("number_last", int'(number_last), int'(b.last));
                        checkOutput("target", int'(target), b.tgt);
                        if (number_last) last_cycle = cycle;
                    end
                end
                if (res_valid) begin
                    if (res_q.size() == 0) begin
                        checkOutput("unexpected_res_valid", 1, 0);
                    end else begin
                        r = res_q.pop_front();
                        checkOutput("res_found", int'(res_found), int'(r.found));
                        checkOutput("res_latency", cycle - last_cycle, 2);
                        if (r.found) begin
                            checkOutput("res_index1", int'(res_index1), r.i1);
                            checkOutput("res_index2", int'(res_index2), r.i2);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst         = 1'b1;
        sel         = 1'b0;
        load_valid  = 1'b0;
        load_last   = 1'b0;
        load_data   = '0;
        load_target = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_load_ready", int'(load_ready), 0);
        checkOutput("reset_number_valid", int'(number_valid), 0);
        checkOutput("reset_number_last", int'(number_last), 0);
        checkOutput("reset_res_valid", int'(res_valid), 0);
        checkOutput("reset_res_found", int'(res_found), 0);
        checkOutput("reset_res_index1", int'(res_index1), 0);
        checkOutput("reset_target", int'(target), 0);
        rst = 1'b0;
        checkOutput("load_ready_first_cycle", int'(load_ready), 0);
        @(posedge clk);
        #1;
        checkOutput("load_ready_rises", int'(load_ready), 1);

        $display("[TB] array [1,0,-1,-2] target -1");
        applyStimulus(4, 1, 0, -1, -2, -1, 1, 4, 1, 1, 2, 1, 0);
        drain("drain_basic_hit");

        $display("[TB] array [1,1] target -2");
        applyStimulus(2, 1, 1, 0, 0, -2, 1, 2, 1, 0, 0, 0, 0);
        drain("drain_no_hit");

        $display("[TB] early exit, array [0,1,-1,-2] target 1");
        sel = 1'b1;
        applyStimulus(4, 0, 1, -1, -2, 1, 1, 3, 1, 1, 1, 0, 0);
        drain("drain_early_exit");
        sel = 1'b0;

        $display("[TB] overflow load [-2,-1,0,1] target -1 without load_last");
        applyStimulus(4, -2, -1, 0, 1, -1, 0, 4, 1, 1, 2, 1, 1);
        drain("drain_overflow");

        $display("[TB] single element [1] target 0");
        applyStimulus(1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
        drain("drain_single");

        $display("[TB] reset during beat 2");
        applyStimulus(4, 1, -2, 0, 0, -1, 1, 4, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_number_valid", int'(number_valid), 0);
        checkOutput("rst_load_ready_low", int'(load_ready), 0);
        @(posedge clk);
        #1;
        checkOutput("rst_load_ready_high", int'(load_ready), 1);

        $display("[TB] after reset, array [0,-2,1] target -1 (hit on final beat)");
        applyStimulus(3, 0, -2, 1, 0, -1, 1, 3, 1, 1, 2, 1, 0);
        drain("drain_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
